pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, operand forwarding and perf counters
// for a five-stage in-order pipeline (IF ID EX MEM WB).
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   id_valid               ID stage holds a real instruction
//   id_rs1/id_rs2/id_rd    ID register numbers (REG_AW bits)
//   id_use_rs1/id_use_rs2  ID actually reads rs1/rs2
//   id_regwrite            ID instruction writes rd
//   id_memread/id_memop    ID is a load / is a load or store
//   ex_branch_taken        branch resolved taken in EX
//   dm_ready               data memory finishes the MEM access this cycle
//   stall_if/stall_id      hold the IF / ID pipeline registers
//   flush_id               squash the instruction in ID
//   bubble_ex              load a bubble into EX
//   freeze                 whole pipeline waits on data memory
//   fwd_a/fwd_b            EX operand select: 00 regfile, 10 MEM, 01 WB
//   cycle_cnt/retire_cnt/stall_cnt  wrapping performance counters

module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memop,
    input  logic              ex_branch_taken,
    input  logic              dm_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memop;
    } stage_t;

    localparam int   EX     = 0;
    localparam int   MEM    = 1;
    localparam int   WB     = 2;
    localparam logic FWD_ON = (FWD_EN != 0);

    // Shadow copies of the instructions currently in EX, MEM and WB.
    stage_t pipe_q [3];
    stage_t id_rec;

    logic dep_ex;
    logic dep_mem;
    logic load_use;
    logic raw_ex;
    logic raw_mem;
    logic hazard;

    // True when a producer with a nonzero rd matches a used ID source.
    function automatic logic reads_rd(
        input stage_t            p,
        input logic              u1,
        input logic              u2,
        input logic [REG_AW-1:0] r1,
        input logic [REG_AW-1:0] r2
    );
        return (p.rd != '0) &&
               ((u1 && (r1 == p.rd)) || (u2 && (r2 == p.rd)));
    endfunction

    function automatic logic writes_reg(input stage_t p);
        return p.valid && p.regwrite && (p.rd != '0);
    endfunction

    // The younger producer (MEM) shadows an older one (WB) on the same rd.
    function automatic logic [1:0] fwd_sel(
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input stage_t            mem,
        input stage_t            wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (FWD_ON && use_src) begin
            if (writes_reg(mem) && (mem.rd == src)) begin
                sel = 2'b10;
            end else if (writes_reg(wb) && (wb.rd == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    always_comb begin
        freeze = pipe_q[MEM].valid && pipe_q[MEM].memop && !dm_ready;

        dep_ex  = reads_rd(pipe_q[EX], id_use_rs1, id_use_rs2,
                           id_rs1, id_rs2);
        dep_mem = reads_rd(pipe_q[MEM], id_use_rs1, id_use_rs2,
                           id_rs1, id_rs2);

        // A load result is never available to EX one cycle later,
        // even with forwarding.
        load_use = pipe_q[EX].valid && pipe_q[EX].memread && dep_ex;

        // Without forwarding, any in-flight writer ahead of WB blocks ID.
        // WB itself is safe: the regfile writes before it is read.
        raw_ex  = pipe_q[EX].valid && pipe_q[EX].regwrite && dep_ex;
        raw_mem = pipe_q[MEM].valid && pipe_q[MEM].regwrite && dep_mem;

        hazard = load_use || (!FWD_ON && (raw_ex || raw_mem));
    end

    // Priority: memory freeze, then taken-branch flush, then RAW stall.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (freeze) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(pipe_q[EX].use_rs1, pipe_q[EX].rs1,
                        pipe_q[MEM], pipe_q[WB]);
        fwd_b = fwd_sel(pipe_q[EX].use_rs2, pipe_q[EX].rs2,
                        pipe_q[MEM], pipe_q[WB]);
    end

    always_comb begin
        id_rec          = '0;
        id_rec.valid    = id_valid && !bubble_ex;
        id_rec.rs1      = id_rs1;
        id_rec.rs2      = id_rs2;
        id_rec.use_rs1  = id_use_rs1;
        id_rec.use_rs2  = id_use_rs2;
        id_rec.rd       = id_rd;
        id_rec.regwrite = id_regwrite;
        id_rec.memread  = id_memread;
        id_rec.memop    = id_memop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pipe_q[i].valid <= 1'b0;
            end
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pipe_q[WB].valid && !freeze) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (stall_id) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!freeze) begin
                pipe_q[WB]  <= pipe_q[MEM];
                pipe_q[MEM] <= pipe_q[EX];
                pipe_q[EX]  <= id_rec;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a forwarding instance (CNT_W=32)
// and a stall-only instance (CNT_W=4) share one randomized stimulus stream.

module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          id_regwrite, id_memread, id_memop;
    logic          ex_branch_taken, dm_ready;

    logic        f_sif, f_sid, f_fl, f_bub, f_frz;
    logic [1:0]  f_fa, f_fb;
    logic [31:0] f_cyc, f_ret, f_stl;
    logic        s_sif, s_sid, s_fl, s_bub, s_frz;
    logic [1:0]  s_fa, s_fb;
    logic [3:0]  s_cyc, s_ret, s_stl;

    pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(32), .FWD_EN(1)) u_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memop(id_memop), .ex_branch_taken(ex_branch_taken),
        .dm_ready(dm_ready), .stall_if(f_sif), .stall_id(f_sid),
        .flush_id(f_fl), .bubble_ex(f_bub), .freeze(f_frz),
        .fwd_a(f_fa), .fwd_b(f_fb), .cycle_cnt(f_cyc),
        .retire_cnt(f_ret), .stall_cnt(f_stl)
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(4), .FWD_EN(0)) u_stl (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memop(id_memop), .ex_branch_taken(ex_branch_taken),
        .dm_ready(dm_ready), .stall_if(s_sif), .stall_id(s_sid),
        .flush_id(s_fl), .bubble_ex(s_bub), .freeze(s_frz),
        .fwd_a(s_fa), .fwd_b(s_fb), .cycle_cnt(s_cyc),
        .retire_cnt(s_ret), .stall_cnt(s_stl)
    );

    // An instruction as seen by the reference model.
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
        bit mo;
    } rec_t;

    // ctl = {stall_if, stall_id, flush_id, bubble_ex, freeze}
    typedef struct {
        bit [4:0] ctl;
        bit [1:0] fa;
        bit [1:0] fb;
        longint   cyc;
        longint   ret;
        longint   stl;
    } exp_t;

    // Model state per instance (0 = forwarding, 1 = stall-only);
    // slot 0 is the instruction in EX, 1 in MEM, 2 in WB.
    rec_t   pipe [2][3];
    longint cyc [2];
    longint ret [2];
    longint stl [2];
    exp_t   q_f[$];
    exp_t   q_s[$];
    bit     last_sid;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic rec_t mk(bit v, int rs1, int rs2, bit u1, bit u2,
                                int rd, bit rw, bit mr, bit mo);
        rec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.rw = rw; r.mr = mr; r.mo = mo;
        return r;
    endfunction

    function automatic rec_t nop();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic longint mask(int c);
        return (c == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    // Does instruction `id` read the register that `p` writes?
    function automatic bit dep(rec_t id, rec_t p);
        if (p.rd == 0) return 0;
        return (id.u1 && id.rs1 == p.rd) || (id.u2 && id.rs2 == p.rd);
    endfunction

    // Nearest older writer of `rs` past EX supplies the operand.
    function automatic bit [1:0] fwd_of(int c, bit u, int rs);
        if (c == 1 || !u) return 2'b00;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[c][s].v && pipe[c][s].rw && pipe[c][s].rd != 0 &&
                pipe[c][s].rd == rs)
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic rec_t rnd_instr();
        rec_t r;
        int k;
        k = $urandom_range(0, 3);
        r = mk($urandom_range(0, 9) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 0, 0, 0);
        case (k)
            0: r.rw = 1;
            1: begin r.rw = 1; r.mr = 1; r.mo = 1; end
            2: r.mo = 1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h @%0t", nm, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected response of both
    // instances, then advance the model across the coming clock edge.
    task automatic step(input rec_t id, input bit br, input bit rdy,
                        input bit rst);
        exp_t e;
        bit   frz;
        bit   haz;
        reset           = rst;
        id_valid        = id.v;
        id_rs1          = AW'(id.rs1);
        id_rs2          = AW'(id.rs2);
        id_rd           = AW'(id.rd);
        id_use_rs1      = id.u1;
        id_use_rs2      = id.u2;
        id_regwrite     = id.rw;
        id_memread      = id.mr;
        id_memop        = id.mo;
        ex_branch_taken = br;
        dm_ready        = rdy;
        for (int c = 0; c < 2; c++) begin
            frz = pipe[c][1].v && pipe[c][1].mo && !rdy;
            haz = pipe[c][0].v && pipe[c][0].mr && dep(id, pipe[c][0]);
            if (c == 1) begin
                for (int s = 0; s < 2; s++)
                    haz |= pipe[c][s].v && pipe[c][s].rw && dep(id, pipe[c][s]);
            end
            if (frz)      e.ctl = 5'b11001;
            else if (br)  e.ctl = 5'b00110;
            else if (haz) e.ctl = 5'b11010;
            else          e.ctl = 5'b00000;
            e.fa  = fwd_of(c, pipe[c][0].u1, pipe[c][0].rs1);
            e.fb  = fwd_of(c, pipe[c][0].u2, pipe[c][0].rs2);
            e.cyc = cyc[c];
            e.ret = ret[c];
            e.stl = stl[c];
            if (c == 0) begin
                q_f.push_back(e);
                last_sid = e.ctl[3];
            end else begin
                q_s.push_back(e);
            end
            if (rst) begin
                for (int s = 0; s < 3; s++) pipe[c][s] = mk(0,0,0,0,0,0,0,0,0);
                cyc[c] = 0; ret[c] = 0; stl[c] = 0;
            end else begin
                cyc[c] = (cyc[c] + 1) & mask(c);
                if (pipe[c][2].v && !frz) ret[c] = (ret[c] + 1) & mask(c);
                if (e.ctl[3]) stl[c] = (stl[c] + 1) & mask(c);
                if (!frz) begin
                    pipe[c][2] = pipe[c][1];
                    pipe[c][1] = pipe[c][0];
                    pipe[c][0] = id;
                    pipe[c][0].v = id.v && !e.ctl[1];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: both instances present a response every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_f.size() > 0) begin
                e = q_f.pop_front();
                chk("fwd.ctl", 64'({f_sif, f_sid, f_fl, f_bub, f_frz}),
                    64'(e.ctl));
                chk("fwd.fwd_a", 64'(f_fa), 64'(e.fa));
                chk("fwd.fwd_b", 64'(f_fb), 64'(e.fb));
                chk("fwd.cycle_cnt", 64'(f_cyc), e.cyc);
                chk("fwd.retire_cnt", 64'(f_ret), e.ret);
                chk("fwd.stall_cnt", 64'(f_stl), e.stl);
            end
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("stl.ctl", 64'({s_sif, s_sid, s_fl, s_bub, s_frz}),
                    64'(e.ctl));
                chk("stl.fwd_a", 64'(s_fa), 64'(e.fa));
                chk("stl.fwd_b", 64'(s_fb), 64'(e.fb));
                chk("stl.cycle_cnt", 64'(s_cyc), e.cyc);
                chk("stl.retire_cnt", 64'(s_ret), e.ret);
                chk("stl.stall_cnt", 64'(s_stl), e.stl);
            end
        end
    end

    initial begin
        rec_t ld5, add6, add5, sub7, ld3, addx0, usex0, cur;
        ld5   = mk(1, 0, 0, 0, 0, 5, 1, 1, 1);
        add6  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0);
        add5  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0);
        sub7  = mk(1, 5, 5, 1, 1, 7, 1, 0, 0);
        ld3   = mk(1, 0, 0, 0, 0, 3, 1, 1, 1);
        addx0 = mk(1, 1, 2, 1, 1, 0, 1, 0, 0);
        usex0 = mk(1, 0, 0, 1, 1, 4, 1, 0, 0);

        reset = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0;
        id_memread = 0; id_memop = 0; ex_branch_taken = 0; dm_ready = 1;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) pipe[c][s] = mk(0,0,0,0,0,0,0,0,0);
            cyc[c] = 0; ret[c] = 0; stl[c] = 0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Load followed by a dependent add, add held while stalled.
        step(ld5, 0, 1, 0);
        step(add6, 0, 1, 0);
        step(add6, 0, 1, 0);
        repeat (4) step(nop(), 0, 1, 0);

        // ALU result consumed back-to-back.
        step(add5, 0, 1, 0);
        repeat (3) step(sub7, 0, 1, 0);
        repeat (3) step(nop(), 0, 1, 0);

        // Load stuck in MEM for three cycles.
        step(ld3, 0, 1, 0);
        step(nop(), 0, 1, 0);
        repeat (3) step(nop(), 0, 0, 0);
        repeat (3) step(nop(), 0, 1, 0);

        // Taken branch on top of a load-use, then on top of a freeze.
        step(ld5, 0, 1, 0);
        step(add6, 1, 1, 0);
        step(ld3, 0, 1, 0);
        step(nop(), 0, 1, 0);
        repeat (2) step(nop(), 1, 0, 0);
        step(nop(), 1, 1, 0);
        repeat (3) step(nop(), 0, 1, 0);

        // Writer of x0 never creates a dependency.
        step(addx0, 0, 1, 0);
        step(usex0, 0, 1, 0);
        repeat (3) step(nop(), 0, 1, 0);

        // Counter wrap on the narrow instance, then reset during a freeze.
        step(nop(), 0, 1, 1);
        repeat (20) step(nop(), 0, 1, 0);
        step(ld3, 0, 1, 0);
        step(nop(), 0, 1, 0);
        step(nop(), 0, 0, 0);
        step(nop(), 0, 0, 1);
        repeat (2) step(nop(), 0, 0, 0);

        cur = rnd_instr();
        for (int n = 0; n < 1500; n++) begin
            if (!last_sid) cur = rnd_instr();
            step(cur, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drain", 64'(q_f.size() + q_s.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
